// File: rtl/fpa_accumulator_if.sv
// Handshake bundle between an operand producer, the frame accumulator and the result sink.
// slave is the accumulator side; master is the producer/consumer side.
interface fpa_accumulator_if #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23,
    parameter int COUNT_WIDTH = 16
);
    logic                          in_valid;
    logic                          in_ready;
    logic [EXP_SIZE+MANTIS_SIZE:0] in_data;
    logic                          in_last;
    logic                          out_valid;
    logic                          out_ready;
    logic [EXP_SIZE+MANTIS_SIZE:0] out_sum;
    logic [COUNT_WIDTH-1:0]        out_count;
    logic                          out_count_sat;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_count_sat
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_count_sat
    );
endinterface

// File: rtl/fpa_accumulator.sv
// Streaming floating-point frame accumulator: folds each accepted operand into a running
// sum through a combinational IEEE-style adder and hands {sum, count} to the sink.
module fpa #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23
) (
    input  logic [EXP_SIZE+MANTIS_SIZE:0] number_A,
    input  logic [EXP_SIZE+MANTIS_SIZE:0] number_B,
    output logic [EXP_SIZE+MANTIS_SIZE:0] number_out
);
    localparam int E  = EXP_SIZE;
    localparam int M  = MANTIS_SIZE;
    localparam int N  = 1 + E + M;
    localparam int SW = M + 5;
    localparam int EW = E + 1;
    localparam int MW = M + 2;
    localparam logic [E:0]   E_ONE = EW'(1);
    localparam logic [E:0]   EINF  = {1'b0, {E{1'b1}}};
    localparam logic [N-1:0] QNAN  = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    function automatic logic is_nan(input logic [N-1:0] x);
        return (&x[N-2:M]) && (|x[M-1:0]);
    endfunction

    function automatic logic is_inf(input logic [N-1:0] x);
        return (&x[N-2:M]) && !(|x[M-1:0]);
    endfunction

    // sig = {hidden, mantissa, guard, round, sticky}; nearest-even, overflow goes to Inf.
    function automatic logic [N-1:0] round_pack(input logic sgn, input logic [E:0] exp_in,
                                                input logic [M+3:0] sig);
        logic [M+1:0] mant;
        logic [E:0]   exp_r;
        mant  = {1'b0, sig[M+3:3]};
        exp_r = exp_in;
        if (sig[2] && (sig[3] || sig[1] || sig[0])) mant = mant + MW'(1);
        if (mant[M+1]) begin
            mant  = mant >> 1;
            exp_r = exp_r + E_ONE;
        end
        if (exp_r >= EINF) return {sgn, {E{1'b1}}, {M{1'b0}}};
        return {sgn, (mant[M] ? exp_r[E-1:0] : {E{1'b0}}), mant[M-1:0]};
    endfunction

    function automatic logic [N-1:0] fp_add(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0]  big, sml;
        logic [E:0]    x_big, x_sml, exp_r;
        logic [SW-1:0] s_big, s_sml, sum;
        logic          sticky;
        int            diff;
        if (is_nan(a)) return a;
        if (is_nan(b)) return b;
        if (is_inf(a) && is_inf(b) && (a[N-1] != b[N-1])) return QNAN;
        if (is_inf(a)) return a;
        if (is_inf(b)) return b;
        if (a[N-2:0] >= b[N-2:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        // Denormals share the minimum normal exponent, just without the hidden one.
        x_big = (big[N-2:M] == '0) ? E_ONE : {1'b0, big[N-2:M]};
        x_sml = (sml[N-2:M] == '0) ? E_ONE : {1'b0, sml[N-2:M]};
        s_big = {1'b0, |big[N-2:M], big[M-1:0], 3'b000};
        s_sml = {1'b0, |sml[N-2:M], sml[M-1:0], 3'b000};
        diff  = int'(x_big - x_sml);
        for (int i = 0; i < SW; i++) begin
            if (i < diff) begin
                sticky   = s_sml[0];
                s_sml    = s_sml >> 1;
                s_sml[0] = s_sml[0] | sticky;
            end
        end
        if (big[N-1] == sml[N-1]) sum = s_big + s_sml;
        else                      sum = s_big - s_sml;
        if (sum == '0) return {a[N-1] & b[N-1], {(N-1){1'b0}}};
        exp_r = x_big;
        if (sum[SW-1]) begin
            sum   = {1'b0, sum[SW-1:2], sum[1] | sum[0]};
            exp_r = exp_r + E_ONE;
        end else begin
            for (int i = 0; i < SW; i++) begin
                if (!sum[SW-2] && (exp_r > E_ONE)) begin
                    sum   = sum << 1;
                    exp_r = exp_r - E_ONE;
                end
            end
        end
        return round_pack(big[N-1], exp_r, sum[SW-2:0]);
    endfunction

    assign number_out = fp_add(number_A, number_B);
endmodule

module fpa_accumulator #(
    parameter int EXP_SIZE    = 8,
    parameter int MANTIS_SIZE = 23,
    parameter int COUNT_WIDTH = 16
) (
    input logic              clk,
    input logic              rst,
    fpa_accumulator_if.slave bus
);
    localparam int N = 1 + EXP_SIZE + MANTIS_SIZE;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t                 r_state, w_state_nxt;
    logic [N-1:0]           r_acc, w_acc_nxt, w_fpa_sum;
    logic [COUNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                   r_sat, w_sat_nxt;
    logic                   r_out_valid, r_out_sat;
    logic [N-1:0]           r_out_sum;
    logic [COUNT_WIDTH-1:0] r_out_count;
    logic                   w_in_ready, w_in_xfer, w_out_load, w_out_clr;

    fpa #(.EXP_SIZE(EXP_SIZE), .MANTIS_SIZE(MANTIS_SIZE)) u_fpa (
        .number_A   (r_acc),
        .number_B   (bus.in_data),
        .number_out (w_fpa_sum)
    );

    assign w_in_ready = (r_state != HOLD);
    assign w_in_xfer  = bus.in_valid & w_in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_sat_nxt   = r_sat;
        w_out_load  = 1'b0;
        w_out_clr   = 1'b0;
        case (r_state)
            IDLE: begin
                // First operand is loaded raw so -0 and NaN payloads survive.
                if (w_in_xfer) begin
                    w_acc_nxt   = bus.in_data;
                    w_count_nxt = COUNT_WIDTH'(1);
                    w_sat_nxt   = 1'b0;
                    w_state_nxt = bus.in_last ? HOLD : ACCUM;
                    w_out_load  = bus.in_last;
                end
            end
            ACCUM: begin
                if (w_in_xfer) begin
                    w_acc_nxt = w_fpa_sum;
                    if (&r_count) w_sat_nxt   = 1'b1;
                    else          w_count_nxt = r_count + COUNT_WIDTH'(1);
                    if (bus.in_last) begin
                        w_state_nxt = HOLD;
                        w_out_load  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_acc_nxt   = '0;
                    w_count_nxt = '0;
                    w_sat_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                    w_out_clr   = 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else begin
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
            r_sat   <= w_sat_nxt;
            if (w_out_load) begin
                r_out_valid <= 1'b1;
                r_out_sum   <= w_acc_nxt;
                r_out_count <= w_count_nxt;
                r_out_sat   <= w_sat_nxt;
            end else if (w_out_clr) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_valid     = r_out_valid;
    assign bus.out_sum       = r_out_sum;
    assign bus.out_count     = r_out_count;
    assign bus.out_count_sat = r_out_sat;
endmodule

// File: tb/tb_fpa_accumulator.sv
// Directed bench for fpa_accumulator: a default instance plus a 2-bit counter instance
// for the saturation case.
module tb_fpa_accumulator;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fpa_accumulator_if #(.EXP_SIZE(8), .MANTIS_SIZE(23), .COUNT_WIDTH(16)) bus ();
    fpa_accumulator_if #(.EXP_SIZE(8), .MANTIS_SIZE(23), .COUNT_WIDTH(2))  bus2 ();

    fpa_accumulator #(.EXP_SIZE(8), .MANTIS_SIZE(23), .COUNT_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fpa_accumulator #(.EXP_SIZE(8), .MANTIS_SIZE(23), .COUNT_WIDTH(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input logic [31:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic push2(input logic [31:0] d, input logic last);
        bus2.in_valid = 1'b1;
        bus2.in_data  = d;
        bus2.in_last  = last;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        bus2.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_sum !== 32'h0) begin errors++; $display("FAIL rst_out_sum got %h want 00000000", bus.out_sum); end
        checks++; if (bus.out_count !== 16'd0) begin errors++; $display("FAIL rst_out_count got %0d want 0", bus.out_count); end
        checks++; if (bus.out_count_sat !== 1'b0) begin errors++; $display("FAIL rst_out_sat got %b want 0", bus.out_count_sat); end
    endtask

    task automatic test_sum_basic();
        bus.out_ready = 1'b1;
        push(32'h3F800000, 1'b0);
        push(32'h40000000, 1'b0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %b want 0", bus.out_valid); end
        push(32'h40400000, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.out_valid); end
        checks++; if (bus.out_sum !== 32'h40C00000) begin errors++; $display("FAIL basic_sum got %h want 40c00000", bus.out_sum); end
        checks++; if (bus.out_count !== 16'd3) begin errors++; $display("FAIL basic_count got %0d want 3", bus.out_count); end
        checks++; if (bus.out_count_sat !== 1'b0) begin errors++; $display("FAIL basic_sat got %b want 0", bus.out_count_sat); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL basic_hold_ready got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_drain_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_neg_zero();
        push(32'h80000000, 1'b1);
        checks++; if (bus.out_sum !== 32'h80000000) begin errors++; $display("FAIL negzero_sum got %h want 80000000", bus.out_sum); end
        checks++; if (bus.out_count !== 16'd1) begin errors++; $display("FAIL negzero_count got %0d want 1", bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_inf();
        push(32'h7F800000, 1'b0);
        push(32'h3F800000, 1'b1);
        checks++; if (bus.out_sum !== 32'h7F800000) begin errors++; $display("FAIL inf_sum got %h want 7f800000", bus.out_sum); end
        checks++; if (bus.out_count !== 16'd2) begin errors++; $display("FAIL inf_count got %0d want 2", bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        push(32'h40000000, 1'b0);
        push(32'h40000000, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h3F800000;
        bus.in_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid cyc %0d got %b want 1", i, bus.out_valid); end
            checks++; if (bus.out_sum !== 32'h40800000) begin errors++; $display("FAIL bp_sum cyc %0d got %h want 40800000", i, bus.out_sum); end
            checks++; if (bus.out_count !== 16'd2) begin errors++; $display("FAIL bp_count cyc %0d got %0d want 2", i, bus.out_count); end
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc %0d got %b want 0", i, bus.in_ready); end
            @(posedge clk); #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_count_sat();
        bus2.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) push2(32'h3F800000, (i == 4));
        checks++; if (bus2.out_sum !== 32'h40A00000) begin errors++; $display("FAIL sat_sum got %h want 40a00000", bus2.out_sum); end
        checks++; if (bus2.out_count !== 2'd3) begin errors++; $display("FAIL sat_count got %0d want 3", bus2.out_count); end
        checks++; if (bus2.out_count_sat !== 1'b1) begin errors++; $display("FAIL sat_flag got %b want 1", bus2.out_count_sat); end
        @(posedge clk); #1;
        push2(32'h3F800000, 1'b1);
        checks++; if (bus2.out_count_sat !== 1'b0) begin errors++; $display("FAIL sat_next_flag got %b want 0", bus2.out_count_sat); end
        checks++; if (bus2.out_count !== 2'd1) begin errors++; $display("FAIL sat_next_count got %0d want 1", bus2.out_count); end
        checks++; if (bus2.out_sum !== 32'h3F800000) begin errors++; $display("FAIL sat_next_sum got %h want 3f800000", bus2.out_sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midframe();
        bus.out_ready = 1'b1;
        push(32'h3F800000, 1'b0);
        push(32'h3F800000, 1'b0);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready got %b want 1", bus.in_ready); end
        rst = 1'b0;
        @(posedge clk); #1;
        push(32'h40000000, 1'b1);
        checks++; if (bus.out_sum !== 32'h40000000) begin errors++; $display("FAIL mid_next_sum got %h want 40000000", bus.out_sum); end
        checks++; if (bus.out_count !== 16'd1) begin errors++; $display("FAIL mid_next_count got %0d want 1", bus.out_count); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_hold();
        bus.out_ready = 1'b0;
        push(32'h40400000, 1'b1);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL hold_pre_valid got %b want 1", bus.out_valid); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL hold_rst_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL hold_rst_ready got %b want 1", bus.in_ready); end
        checks++; if (bus.out_sum !== 32'h0) begin errors++; $display("FAIL hold_rst_sum got %h want 00000000", bus.out_sum); end
        checks++; if (bus.out_count !== 16'd0) begin errors++; $display("FAIL hold_rst_count got %0d want 0", bus.out_count); end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_data    = 32'h0;
        bus.in_last    = 1'b0;
        bus.out_ready  = 1'b0;
        bus2.in_valid  = 1'b0;
        bus2.in_data   = 32'h0;
        bus2.in_last   = 1'b0;
        bus2.out_ready = 1'b0;
        #12;
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_sum_basic();
        test_neg_zero();
        test_inf();
        test_backpressure();
        test_count_sat();
        test_reset_midframe();
        test_reset_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fpa_accumulator.md
Name: fpa_accumulator

Overview:
- Streaming floating-point sum stage wrapped around the combinational fpa adder (instantiated internally).
- Accepts a frame of IEEE-style operands over a valid/ready handshake and folds each one into a running accumulator register, at one operand per clock.
- Presents the frame sum and element count on a second valid/ready handshake to the downstream consumer.
- Sits between an operand producer (memory reader or DSP front end) and a result sink.

Parameters:
- EXP_SIZE, `EXP_SIZE (8): exponent field width; passed through to fpa.
- MANTIS_SIZE, `MANTIS_SIZE (23): mantissa field width; passed through to fpa.
- COUNT_WIDTH, 16: width of the element counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  in_data/in_last are valid.
- in_ready  output  1  block accepts an operand this cycle.
- in_data  input  1+EXP_SIZE+MANTIS_SIZE  operand {sign, exp, mantis}.
- in_last  input  1  marks the final operand of the frame.
- out_valid  output  1  out_sum/out_count/out_count_sat are valid.
- out_ready  input  1  consumer takes the result.
- out_sum  output  1+EXP_SIZE+MANTIS_SIZE  frame sum.
- out_count  output  COUNT_WIDTH  number of operands accepted in the frame (saturating).
- out_count_sat  output  1  counter saturated during the frame.

Behaviour:
- Reset is one clock domain, asynchronous and active-high (rst). On rst: state=IDLE, acc=0, count=0, sat=0, out_valid=0, out_sum=0, out_count=0, out_count_sat=0.
- Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
- in_ready = (state != HOLD). It is combinational from state only and never depends on in_valid.
- fpa is instantiated with number_A=acc and number_B=in_data. The acc->fpa->acc loop is a single-cycle combinational path with no extra pipelining.
- State IDLE (no operand held):
  - On an input transfer: acc<=in_data (loaded directly, not added to +0, so -0 and NaN payloads are preserved); count<=1; sat<=0.
  - If in_last is also set, go to HOLD; otherwise go to ACCUM.
- State ACCUM:
  - On an input transfer: acc<=fpa.number_out.
  - count<=count+1 if count != all-ones; otherwise hold count and set sat<=1.
  - If in_last, go to HOLD.
  - No transfer: all registers hold.
- Entering HOLD (registered on the same edge as the last transfer):
  - out_sum<=the new acc value; out_count<=the new count; out_count_sat<=the new sat; out_valid<=1.
  - Latency: the result is visible the cycle after the last operand is accepted.
- State HOLD:
  - Outputs stay stable while out_ready=0 (backpressure of unlimited length).
  - On an output transfer: out_valid<=0, acc<=0, count<=0, sat<=0, state<=IDLE.
  - The next frame's first operand can be accepted the cycle after that.
- Special values (NaN, Inf, denormals, rounding) are exactly as produced by fpa; this block adds no arithmetic of its own.
- Simultaneous events: in_valid is ignored in HOLD. An input and an output transfer cannot occur in the same cycle.
- in_data, in_last and in_valid are don't-care when no input transfer occurs.
- rst asserted mid-frame or in HOLD discards the partial sum and pending result immediately (asynchronous), without waiting for a clock edge.
- Frames are at least one element long; there is no empty-frame result.

Test Plan:
- Frame {0x3F800000, 0x40000000, 0x40400000(last)} (1.0, 2.0, 3.0), out_ready=1 -> out_valid one cycle after the third transfer, out_sum=0x40C00000 (6.0), out_count=3, out_count_sat=0.
- Single-element frame 0x80000000 with in_last=1 -> out_sum=0x80000000 (-0 preserved), out_count=1.
- Frame {0x7F800000, 0x3F800000(last)} (+Inf + 1.0) -> out_sum=0x7F800000, out_count=2.
- Backpressure: out_ready=0 for 5 cycles after a 2.0+2.0 frame -> out_sum=0x40800000 stable, in_ready=0 throughout; out_ready=1 -> IDLE, in_ready=1 on the next cycle.
- COUNT_WIDTH=2, five operands of 0x3F800000 -> out_sum=0x40A00000, out_count=3, out_count_sat=1; the next frame reports sat=0.
- Reset mid-frame: two operands accepted, pulse rst asynchronously between edges -> out_valid=0 and in_ready=1 immediately; next frame {0x40000000(last)} gives out_sum=0x40000000, out_count=1.
